ex_stage_hs: RTL
================

Name: ex_stage_hs

Overview:
Parametrised execute stage for the pipelined CPU. It replaces the fixed 16-bit, always-advancing execute stage with a valid/ready-handshaked stage. It has a single output pipeline register, an iterative multi-cycle multiplier, result flags, and a flush input. It sits between decode/register-read and writeback, and forwards dr_addr, imm and op_code alongside the result.

Parameters:
DATA_W, 16, datapath width (≥4, power of two)
REG_AW, 3, destination register address width
OP_W, 4, opcode width
SH_W, $clog2(DATA_W), shift-amount bits taken from tr_data

Ports:
clk_ex  in  1  stage clock, all state on rising edge
rst_ex  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of stage contents (branch redirect)
in_valid  in  1  upstream operation valid
in_ready  out  1  stage can accept this cycle
op_code_0  in  OP_W  operation
dr_addr_0  in  REG_AW  destination register
sr_data  in  DATA_W  source operand A
tr_data  in  DATA_W  source operand B
imm_0  in  DATA_W  immediate
out_valid  out  1  result register holds a valid op
out_ready  in  1  downstream accepts result
alu_out  out  DATA_W  result
dr_addr_1  out  REG_AW  registered dr_addr_0
imm_1  out  DATA_W  registered imm_0
op_code_1  out  OP_W  registered op_code_0
flag_z  out  1  alu_out == 0 (registered with result)
flag_c  out  1  carry/borrow (ADD/ADDI carry-out, SUB borrow), else 0
busy  out  1  multiplier FSM not IDLE

Behaviour:
- Reset (async, rst_ex=1): state=IDLE; out_valid, alu_out, dr_addr_1, imm_1, op_code_1, flag_z, flag_c, busy = 0; multiplier regs = 0.
- Opcodes:
  - 0 NOP: result 0
  - 1 ADD: A+B
  - 2 SUB: A-B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SLL: A << B[SH_W-1:0]
  - 7 SRL: A >> B[SH_W-1:0], logical
  - 8 ADDI: A+imm
  - 9 LDI: result = imm
  - 10 MUL: low DATA_W bits of A*B
  - 11..15: treated as NOP, still passed through with out_valid.
- Arithmetic is modulo 2^DATA_W. Carry is computed from a DATA_W+1-bit sum.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready.
- Single-cycle ops: the accept cycle's result is loaded into the output register at the next edge; out_valid=1. Latency is 1 cycle. Back-to-back ops give full throughput when out_ready=1.
- Output register holds all outputs stable while out_valid && !out_ready.
- out_valid clears when out_ready=1 and no new result is loaded the same edge.
- MUL FSM states:
  - IDLE: on a MUL accept, latch A, B, dr_addr, imm, op and clear the accumulator; go to BUSY, cnt=0.
  - BUSY: shift-add 1 bit per cycle (acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1); cnt++. When cnt==DATA_W-1, go to DONE.
  - DONE: wait until !out_valid || out_ready, then load acc into alu_out with latched sideband, set out_valid, go to IDLE.
- MUL latency is DATA_W+1 cycles from accept to out_valid when downstream is ready. in_ready=0 throughout BUSY/DONE.
- MUL flags: flag_z from product, flag_c=0.
- flush=1 at an edge:
  - out_valid←0.
  - FSM→IDLE, multiplier abandoned with no output.
  - Nothing is accepted that cycle.
  - Flush dominates out_ready and DONE loading.
- Simultaneous out_ready and accept on the same edge: the new result replaces the old one; out_valid stays 1.
- Reset asserted mid-MUL aborts immediately to the reset values.

Decomposition:
- Shared package ex_pkg: opcode localparams (OP_NOP..OP_MUL) and an FSM state enum (IDLE, BUSY, DONE).
- One sub-module, ex_mul_iter: the shift-add multiplier with start/done.
- The combinational ALU stays inline in ex_stage_hs.

Test Plan:
- Reset mid-operation: out_valid=0, alu_out=0, busy=0 immediately, with no clock edge needed.
- ADD 0xFFFF+0x0001, dr_addr=5, out_ready=1 → next cycle: alu_out=0x0000, flag_z=1, flag_c=1, dr_addr_1=5, out_valid=1.
- SUB 0x0003-0x0005 → alu_out=0xFFFE, flag_c=1. SLL 0x0001 by tr_data=0x0013 (uses 3) → 0x0008.
- MUL 0x0012*0x0034 → in_ready=0 for 17 cycles, busy=1; then alu_out=0x03A8, out_valid=1, flag_c=0.
- Backpressure: three ADDs with out_ready=0 after the first → first result held stable, in_ready=0, no op lost. Releasing out_ready yields results in order.
- Flush during MUL BUSY (cycle 5) → busy=0 next cycle, no out_valid for the MUL, and the next ADD is accepted the following cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the handshaked execute stage.
// Opcode values and the multiplier FSM state type.
package ex_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one bit per cycle.
// Holds its product in DONE until the stage can take it.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_ex,
    input  logic              rst_ex,
    input  logic              start,
    input  logic              abort,
    input  logic              take,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output mul_state_t        state,
    output logic [DATA_W-1:0] product
);

    localparam int CW = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CW-1:0]     cnt;

    // FSM and datapath: abort wins, then one shift-add step per BUSY cycle
    always_ff @(posedge clk_ex or posedge rst_ex) begin
        if (rst_ex) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    if (take)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: rtl/ex_stage_hs.sv
// Valid/ready execute stage with one output register.
// Inline ALU for single-cycle ops, iterative multiplier for MUL.
module ex_stage_hs
    import ex_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int OP_W   = 4,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk_ex,
    input  logic              rst_ex,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_code_0,
    input  logic [REG_AW-1:0] dr_addr_0,
    input  logic [DATA_W-1:0] sr_data,
    input  logic [DATA_W-1:0] tr_data,
    input  logic [DATA_W-1:0] imm_0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_AW-1:0] dr_addr_1,
    output logic [DATA_W-1:0] imm_1,
    output logic [OP_W-1:0]   op_code_1,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);

    mul_state_t        mstate;
    logic [DATA_W-1:0] mprod;
    logic              take;
    logic              accept;
    logic              is_mul;
    logic              mul_start;
    logic              mul_load;

    logic [DATA_W:0]   add_ab;
    logic [DATA_W:0]   sub_ab;
    logic [DATA_W:0]   add_ai;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    logic [REG_AW-1:0] m_dr;
    logic [DATA_W-1:0] m_imm;
    logic [OP_W-1:0]   m_op;

    assign take      = !out_valid || out_ready;
    assign in_ready  = (mstate == IDLE) && take && !flush;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op_code_0 == OP_W'(OP_MUL));
    assign mul_start = accept && is_mul;
    assign mul_load  = (mstate == DONE) && take;
    assign busy      = (mstate != IDLE);

    assign add_ab = {1'b0, sr_data} + {1'b0, tr_data};
    assign sub_ab = {1'b0, sr_data} - {1'b0, tr_data};
    assign add_ai = {1'b0, sr_data} + {1'b0, imm_0};

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_ex  (clk_ex),
        .rst_ex  (rst_ex),
        .start   (mul_start),
        .abort   (flush),
        .take    (take),
        .a       (sr_data),
        .b       (tr_data),
        .state   (mstate),
        .product (mprod)
    );

    // Single-cycle ALU result and carry/borrow
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_code_0)
            OP_W'(OP_ADD): begin
                alu_res = add_ab[DATA_W-1:0];
                alu_c   = add_ab[DATA_W];
            end
            OP_W'(OP_SUB): begin
                alu_res = sub_ab[DATA_W-1:0];
                alu_c   = sub_ab[DATA_W];
            end
            OP_W'(OP_AND):  alu_res = sr_data & tr_data;
            OP_W'(OP_OR):   alu_res = sr_data | tr_data;
            OP_W'(OP_XOR):  alu_res = sr_data ^ tr_data;
            OP_W'(OP_SLL):  alu_res = sr_data << tr_data[SH_W-1:0];
            OP_W'(OP_SRL):  alu_res = sr_data >> tr_data[SH_W-1:0];
            OP_W'(OP_ADDI): begin
                alu_res = add_ai[DATA_W-1:0];
                alu_c   = add_ai[DATA_W];
            end
            OP_W'(OP_LDI):  alu_res = imm_0;
            default:        alu_res = '0;
        endcase
    end

    // Capture MUL sideband so it leaves with the product
    always_ff @(posedge clk_ex or posedge rst_ex) begin
        if (rst_ex) begin
            m_dr  <= '0;
            m_imm <= '0;
            m_op  <= '0;
        end else if (mul_start) begin
            m_dr  <= dr_addr_0;
            m_imm <= imm_0;
            m_op  <= op_code_0;
        end
    end

    // Output register: flush, then MUL result, then ALU result, then drain
    always_ff @(posedge clk_ex or posedge rst_ex) begin
        if (rst_ex) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            dr_addr_1 <= '0;
            imm_1     <= '0;
            op_code_1 <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (mul_load) begin
            out_valid <= 1'b1;
            alu_out   <= mprod;
            dr_addr_1 <= m_dr;
            imm_1     <= m_imm;
            op_code_1 <= m_op;
            flag_z    <= (mprod == '0);
            flag_c    <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            alu_out   <= alu_res;
            dr_addr_1 <= dr_addr_0;
            imm_1     <= imm_0;
            op_code_1 <= op_code_0;
            flag_z    <= (alu_res == '0);
            flag_c    <= alu_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
